systolic_scheduler: RTL and testbench
=====================================

Name: systolic_scheduler

Overview:
- Parametrised control sequencer for the weight-stationary systolic array.
- Accepts a start handshake and runs a weight-load phase, optionally skipped for weight reuse.
- Then drives staggered per-row multiply enables, ramping in and draining out, for a runtime-selected stream length K.
- Pulses done at the end. Sits between the top-level controller and the PE row-control inputs. Supports non-square arrays and a global stall.

Parameters:
- ROWS, 4, number of PE rows; width of load_weight and enable_mult.
- COLS, 4, number of PE columns; sets drain depth.
- STAGE_CYCLES, 4, enabled clock cycles per pipeline stage (PE multiply latency); must be >= 1.
- K_MAX, 16, maximum input-stream length; sizes k_len.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- general_enable, input, 1, global advance enable; low stalls the sequencer.
- start, input, 1, request a new operation; sampled only in IDLE or DONE with general_enable high.
- reuse_weights, input, 1, sampled with start; 1 skips LOAD.
- k_len, input, $clog2(K_MAX+1), stream length; sampled with start.
- busy, output, 1, high in LOAD and COMPUTE.
- load_weight, output, ROWS, per-row weight-load strobe.
- enable_mult, output, ROWS, per-row multiply enable; bit ROWS-1 is the first row.
- done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset (async, reset=0): state IDLE; all counters 0; busy=0, load_weight=0, enable_mult=0, done=0. Reset mid-operation aborts immediately with no done pulse.
- All outputs are registered: a start accepted at edge t gives first phase outputs in cycle t+1.
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE/DONE + start + general_enable:
  - Latch k_len and reuse_weights.
  - Go to LOAD if reuse_weights=0; else COMPUTE if k_len>0; else DONE.
- DONE lasts exactly one cycle with done=1, then IDLE unless a new start is accepted.
- start outside IDLE/DONE is ignored. There is no queueing.
- LOAD:
  - load_weight = all ones for exactly ROWS enabled cycles.
  - Then COMPUTE, or DONE if the latched k_len=0.
- COMPUTE:
  - Stage index s counts from 0; s increments after every STAGE_CYCLES enabled cycles.
  - S_TOT = ROWS + k_len + COLS - 2.
  - Bit ROWS-1-j of enable_mult is high iff j <= s < j + k_len + COLS - 1.
  - Net shape: a thermometer that ramps in from the MSB one row per stage, then drains from the MSB one row per stage.
  - When s reaches S_TOT, go to DONE; enable_mult=0 in DONE.
- Stall (general_enable=0):
  - State, s, and the cycle prescaler all hold.
  - load_weight and enable_mult are driven 0 in the following cycle.
  - Outputs resume with the held values on the first enabled cycle.
  - done is not asserted while stalled; DONE is held until enable returns, so done still lasts one enabled cycle.
- Widths:
  - Prescaler: $clog2(STAGE_CYCLES) bits, wraps from STAGE_CYCLES-1 to 0.
  - Stage counter: $clog2(ROWS+K_MAX+COLS) bits.
  - No arithmetic overflow for k_len <= K_MAX. For k_len > K_MAX, the value is clamped to K_MAX at sampling.
- STAGE_CYCLES=1: one stage per cycle; the prescaler is removed.

Decomposition:
- Package systolic_pkg:
  - state enum sched_state_t (IDLE, LOAD, COMPUTE, DONE).
  - Width helper constants (stage-counter width, k_len width).
- Sub-module stage_ticker: parametrised STAGE_CYCLES prescaler with enable and clear. It outputs a one-cycle tick on the last cycle of each stage.

Test Plan:
1. Nominal. ROWS=COLS=2, STAGE_CYCLES=4, k_len=2, start at cycle 0:
   - load_weight=11 in cycles 1-2.
   - enable_mult=10 in cycles 3-6, 11 in cycles 7-14, 01 in cycles 15-18.
   - done=1 in cycle 19 only; busy high in cycles 1-18.
2. Reuse. Same config with reuse_weights=1:
   - load_weight is never asserted.
   - enable_mult=10 from cycle 1; done at cycle 17.
3. Stall. Nominal run with general_enable low for cycles 8-10:
   - enable_mult=00 in cycles 9-11.
   - The sequence resumes unchanged; done shifts to cycle 22.
4. Boundaries:
   - k_len=0, reuse=0: load_weight for 2 cycles, then done at cycle 3, no enable_mult.
   - start during COMPUTE: ignored, no change to the sequence.
   - start in the DONE cycle: new LOAD from the next cycle.
5. Reset: reset low in cycle 9 of the nominal run.
   - All outputs go 0 asynchronously and no done pulse occurs.
   - After release, a start reproduces scenario 1 exactly.
6. Non-square. ROWS=4, COLS=2, STAGE_CYCLES=1, k_len=3:
   - S_TOT=7 stages.
   - Rows turn on in cycles 5, 6, 7, 8 (MSB first), each high for 4 cycles.
   - done in cycle 12.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic-array control sequencer.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } sched_state_t;

    function automatic int k_width(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    function automatic int stage_width(input int rows, input int k_max, input int cols);
        return $clog2(rows + k_max + cols);
    endfunction

endpackage

// File: rtl/stage_ticker.sv
// Stage prescaler: counts enabled cycles and ticks on the last cycle of each stage.
module stage_ticker #(
    parameter int STAGE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    generate
        if (STAGE_CYCLES <= 1) begin : g_direct
            // Every enabled cycle closes a stage, so no counter is needed.
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear};
            assign tick = enable;
        end else begin : g_count
            localparam int CW = $clog2(STAGE_CYCLES);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable) begin
                    if (cnt == CW'(STAGE_CYCLES - 1)) cnt <= '0;
                    else                              cnt <= cnt + 1'b1;
                end
            end

            assign tick = enable && (cnt == CW'(STAGE_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/systolic_scheduler.sv
// Weight-stationary systolic array sequencer: optional weight load, staggered
// per-row multiply enables (ramp in / drain out), then a one-cycle done pulse.
module systolic_scheduler
    import systolic_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int STAGE_CYCLES = 4,
    parameter int K_MAX        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          general_enable,
    input  logic                          start,
    input  logic                          reuse_weights,
    input  logic [k_width(K_MAX)-1:0]     k_len,
    output logic                          busy,
    output logic [ROWS-1:0]               load_weight,
    output logic [ROWS-1:0]               enable_mult,
    output logic                          done,
    output sched_state_t                  dbg_state
);

    localparam int KW = k_width(K_MAX);
    localparam int SW = stage_width(ROWS, K_MAX, COLS);
    localparam int LW = $clog2(ROWS + 1);

    // Handshake: start is a request taken on any rising edge where general_enable
    // is high and the sequencer is in IDLE or DONE; at any other time it is dropped.
    sched_state_t  state;
    logic [SW-1:0] stage;
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_in;
    logic [LW-1:0] load_cnt;
    logic          tick;
    int            s_tot;

    assign k_in      = (int'(k_len) > K_MAX) ? KW'(K_MAX) : k_len;
    assign s_tot     = ROWS + int'(k_q) + COLS - 2;
    assign dbg_state = state;

    stage_ticker #(.STAGE_CYCLES(STAGE_CYCLES)) u_ticker (
        .clk    (clk),
        .reset  (reset),
        .enable (general_enable && (state == COMPUTE)),
        .clear  (state != COMPUTE),
        .tick   (tick)
    );

    // Row j (bit ROWS-1-j) multiplies while its skewed window covers stage s.
    function automatic logic [ROWS-1:0] row_mask(input logic [SW-1:0] s, input logic [KW-1:0] k);
        logic [ROWS-1:0] m;
        m = '0;
        for (int j = 0; j < ROWS; j++)
            m[ROWS-1-j] = (int'(s) >= j) && (int'(s) < j + int'(k) + COLS - 1);
        return m;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            stage       <= '0;
            k_q         <= '0;
            load_cnt    <= '0;
            busy        <= 1'b0;
            load_weight <= '0;
            enable_mult <= '0;
            done        <= 1'b0;
        end else if (!general_enable) begin
            load_weight <= '0;
            enable_mult <= '0;
            done        <= 1'b0;
        end else begin
            load_weight <= '0;
            enable_mult <= '0;
            done        <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        k_q      <= k_in;
                        stage    <= '0;
                        load_cnt <= '0;
                        if (!reuse_weights) begin
                            state       <= LOAD;
                            busy        <= 1'b1;
                            load_weight <= '1;
                        end else if (k_in != '0) begin
                            state       <= COMPUTE;
                            busy        <= 1'b1;
                            enable_mult <= row_mask('0, k_in);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_cnt == LW'(ROWS - 1)) begin
                        if (k_q == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= COMPUTE;
                            enable_mult <= row_mask('0, k_q);
                        end
                    end else begin
                        load_cnt    <= load_cnt + 1'b1;
                        load_weight <= '1;
                    end
                end
                COMPUTE: begin
                    if (tick) begin
                        if (int'(stage) + 1 >= s_tot) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            stage <= '0;
                        end else begin
                            stage       <= stage + 1'b1;
                            enable_mult <= row_mask(stage + 1'b1, k_q);
                        end
                    end else begin
                        enable_mult <= row_mask(stage, k_q);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_scheduler.sv
// Bench for systolic_scheduler: a 2x2 (4 cycles/stage) and a 4x2 (1 cycle/stage) instance.
module tb_systolic_scheduler;
    import systolic_pkg::*;

    localparam int A_ROWS = 2, A_COLS = 2, A_SC = 4;
    localparam int B_ROWS = 4, B_COLS = 2, B_SC = 1;
    localparam int K_MAX  = 16;
    localparam int KW     = $clog2(K_MAX + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset, general_enable, start, reuse_weights;
    logic [KW-1:0] k_len;

    always #5 clk = ~clk;

    logic busy_a, done_a, busy_b, done_b;
    logic [A_ROWS-1:0] lw_a, em_a;
    logic [B_ROWS-1:0] lw_b, em_b;
    sched_state_t st_a, st_b;

    int checks = 0;
    int errors = 0;

    systolic_scheduler #(.ROWS(A_ROWS), .COLS(A_COLS), .STAGE_CYCLES(A_SC), .K_MAX(K_MAX)) dut_a (
        .clk(clk), .reset(reset), .general_enable(general_enable), .start(start),
        .reuse_weights(reuse_weights), .k_len(k_len), .busy(busy_a), .load_weight(lw_a),
        .enable_mult(em_a), .done(done_a), .dbg_state(st_a)
    );

    systolic_scheduler #(.ROWS(B_ROWS), .COLS(B_COLS), .STAGE_CYCLES(B_SC), .K_MAX(K_MAX)) dut_b (
        .clk(clk), .reset(reset), .general_enable(general_enable), .start(start),
        .reuse_weights(reuse_weights), .k_len(k_len), .busy(busy_b), .load_weight(lw_b),
        .enable_mult(em_b), .done(done_b), .dbg_state(st_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entry layout: [9] busy, [8:5] load_weight, [4:1] enable_mult, [0] done.
    function automatic logic [31:0] obs_a();
        return {22'b0, busy_a, 2'b0, lw_a, 2'b0, em_a, done_a};
    endfunction

    function automatic logic [31:0] obs_b();
        return {22'b0, busy_b, lw_b, em_b, done_b};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [3:0] spec_mask(input int rows, input int cols, input int k, input int s);
        logic [3:0] m;
        m = '0;
        for (int j = 0; j < rows; j++)
            if (s >= j && s < j + k + cols - 1) m[rows-1-j] = 1'b1;
        return m;
    endfunction

    function automatic int op_len(input int rows, input int cols, input int sc, input int k, input bit reuse);
        return (reuse ? 0 : rows) + ((k == 0) ? 0 : (rows + k + cols - 2) * sc) + 1;
    endfunction

    function automatic logic [9:0] op_entry(input int rows, input int cols, input int sc,
                                            input int k, input bit reuse, input int i);
        int c;
        logic [3:0] all;
        all = 4'((1 << rows) - 1);
        c = i;
        if (!reuse) begin
            if (i < rows) return {1'b1, all, 4'b0, 1'b0};
            c = i - rows;
        end
        if (k > 0 && c < (rows + k + cols - 2) * sc)
            return {1'b1, 4'b0, spec_mask(rows, cols, k, c / sc), 1'b0};
        return {1'b0, 8'b0, 1'b1};
    endfunction

    logic [9:0] exp_q_a[$];
    logic [9:0] exp_q_b[$];
    logic [9:0] cur_a, cur_b;
    logic       ge_q;

    always @(posedge clk or negedge reset) begin
        int k;
        if (!reset) begin
            exp_q_a.delete();
            exp_q_b.delete();
            cur_a = '0;
            cur_b = '0;
            ge_q  = 1'b1;
        end else begin
            k = (int'(k_len) > K_MAX) ? K_MAX : int'(k_len);
            if (general_enable) begin
                if (!cur_a[9] && start) begin
                    exp_q_a.delete();
                    for (int i = 0; i < op_len(A_ROWS, A_COLS, A_SC, k, reuse_weights); i++)
                        exp_q_a.push_back(op_entry(A_ROWS, A_COLS, A_SC, k, reuse_weights, i));
                end
                cur_a = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : 10'b0;
                if (!cur_b[9] && start) begin
                    exp_q_b.delete();
                    for (int i = 0; i < op_len(B_ROWS, B_COLS, B_SC, k, reuse_weights); i++)
                        exp_q_b.push_back(op_entry(B_ROWS, B_COLS, B_SC, k, reuse_weights, i));
                end
                cur_b = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : 10'b0;
            end
            ge_q = general_enable;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [9:0] da, db;
        da = ge_q ? cur_a : {cur_a[9], 9'b0};
        db = ge_q ? cur_b : {cur_b[9], 9'b0};
        check("model_a", obs_a(), {22'b0, da});
        check("model_b", obs_b(), {22'b0, db});
    end

    // ---------------- hand-computed expectations ----------------
    function automatic logic [9:0] plan_nom(input int m);
        logic [9:0] e;
        e    = '0;
        e[9] = (m >= 1 && m <= 18);
        if (m >= 1 && m <= 2) e[6:5] = 2'b11;
        if (m >= 3 && m <= 6)       e[2:1] = 2'b10;
        else if (m >= 7 && m <= 14) e[2:1] = 2'b11;
        else if (m >= 15 && m <= 18) e[2:1] = 2'b01;
        e[0] = (m == 19);
        return e;
    endfunction

    function automatic logic [9:0] plan_b(input int n);
        logic [9:0] e;
        e    = '0;
        e[9] = (n >= 1 && n <= 11);
        if (n >= 1 && n <= 4) e[8:5] = 4'hf;
        for (int j = 0; j < 4; j++)
            if (n >= 5 + j && n <= 8 + j) e[4 - j] = 1'b1;
        e[0] = (n == 12);
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        start = 1'b0;
        general_enable = 1'b1;
        @(negedge clk);
        while ((busy_a || busy_b) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(n < 400), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_a(input string tag, input bit reuse, input bit stall,
                         input int ign_cyc, input bit restart);
        int last, m;
        logic [9:0] e;
        last = reuse ? 17 : (stall ? 22 : 19);
        @(negedge clk);
        start = 1'b1; reuse_weights = reuse; k_len = 5'd2; general_enable = 1'b1;
        for (int n = 1; n <= last + 1; n++) begin
            @(negedge clk);
            start = 1'b0;
            m = reuse ? n + 2 : n;
            if (stall && n > 11) m = n - 3;
            e = plan_nom(m);
            if (stall && n >= 9 && n <= 11) e = {1'b1, 9'b0};
            if (restart && n == last + 1) e = {1'b1, 4'b0011, 4'b0000, 1'b0};
            check({tag, "_out"}, obs_a(), {22'b0, e});
            if (!reuse && !stall && n == 1)  check({tag, "_st_load"}, 32'(st_a), 32'(LOAD));
            if (!reuse && !stall && n == 3)  check({tag, "_st_comp"}, 32'(st_a), 32'(COMPUTE));
            if (!reuse && !stall && n == 19) check({tag, "_st_done"}, 32'(st_a), 32'(DONE));
            if (stall && n == 8)  general_enable = 1'b0;
            if (stall && n == 11) general_enable = 1'b1;
            if (n == ign_cyc) begin start = 1'b1; reuse_weights = 1'b1; k_len = 5'd7; end
            if (restart && n == last) begin start = 1'b1; reuse_weights = 1'b0; k_len = 5'd2; end
        end
        wait_idle(tag);
    endtask

    task automatic run_k0(input bit reuse);
        logic [9:0] e;
        @(negedge clk);
        start = 1'b1; reuse_weights = reuse; k_len = 5'd0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (reuse) e = (n == 1) ? 10'b0_0000_0000_1 : 10'b0;
            else if (n <= 2) e = {1'b1, 4'b0011, 4'b0, 1'b0};
            else if (n == 3) e = 10'b0_0000_0000_1;
            else e = 10'b0;
            check(reuse ? "k0_reuse" : "k0_load", obs_a(), {22'b0, e});
        end
        wait_idle("k0");
    endtask

    task automatic run_b();
        @(negedge clk);
        start = 1'b1; reuse_weights = 1'b0; k_len = 5'd3;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            start = 1'b0;
            check("nonsquare", obs_b(), {22'b0, plan_b(n)});
        end
        wait_idle("nonsquare");
    endtask

    task automatic run_reset();
        @(negedge clk);
        start = 1'b1; reuse_weights = 1'b0; k_len = 5'd2;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start = 1'b0;
            check("rst_pre", obs_a(), {22'b0, plan_nom(n)});
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_async_out", obs_a(), 32'd0);
        check("rst_async_st", 32'(st_a), 32'(IDLE));
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("rst_no_done", {31'b0, done_a}, 32'd0);
        end
        #2 reset = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        general_enable = 1'b1; start = 1'b0; reuse_weights = 1'b0; k_len = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", obs_a(), 32'd0);
        check("reset_b", obs_b(), 32'd0);
        check("reset_st", 32'(st_a), 32'(IDLE));
        #2 reset = 1'b1;

        run_a("nominal", 1'b0, 1'b0, 10, 1'b0);
        run_a("reuse",   1'b1, 1'b0, -1, 1'b0);
        run_a("stall",   1'b0, 1'b1, -1, 1'b0);
        run_a("restart", 1'b0, 1'b0, -1, 1'b1);
        run_k0(1'b0);
        run_k0(1'b1);
        run_b();
        run_reset();
        run_a("post_rst", 1'b0, 1'b0, -1, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            general_enable = ($urandom_range(0, 7) != 0);
            start          = ($urandom_range(0, 3) == 0);
            reuse_weights  = 1'($urandom_range(0, 1));
            k_len          = ($urandom_range(0, 4) == 0) ? KW'($urandom_range(0, 31))
                                                         : KW'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
        end
        wait_idle("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
